// File: rtl/resp_packer.sv
// rtl/resp_packer.sv - response FIFO and UART frame serializer with inter-byte gap and byte timeout
// Optional RESP_CHECKSUM_EN appends a code^data checksum byte (3-byte frames instead of 2).
module resp_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       i_Clock,
    input  logic       rst_n,
    input  logic       i_Rsp_Valid,
    input  logic [7:0] i_Rsp_Code,
    input  logic [7:0] i_Rsp_Data,
    output logic       o_Rsp_Ready,
    input  logic       i_Tx_Busy,
    input  logic       i_Tx_Done,
    output logic       o_Tx_Start,
    output logic [7:0] o_Tx_Data,
    output logic       o_Busy,
    output logic       o_Tx_Err,
    output logic       o_Drop,
    output logic [2:0] debug_state
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = AW + 1;
    localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW     = (TW_RAW < 18) ? 18 : TW_RAW;
    localparam int GW     = ($clog2(GAP_CYC + 1) < 1) ? 1 : $clog2(GAP_CYC + 1);
`ifdef RESP_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      frame_code;
    logic [7:0]      frame_data;
    logic [7:0]      tx_data;
    logic [1:0]      byte_idx;
    logic            frame_end;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            timeout;
    logic            gap_last;
    logic            more_bytes;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] c,
                                              input logic [7:0] d);
        case (idx)
            2'd0:    return c;
            2'd1:    return d;
            default: return c ^ d;
        endcase
    endfunction

    assign fifo_empty  = (count == '0);
    assign o_Rsp_Ready = (count != CW'(FIFO_DEPTH));
    assign push        = i_Rsp_Valid & o_Rsp_Ready;
    assign pop         = (state == LOAD);
    assign o_Drop      = i_Rsp_Valid & ~o_Rsp_Ready;
    assign o_Busy      = !fifo_empty || (state != IDLE);
    assign o_Tx_Data   = tx_data;
    assign debug_state = state;
    assign timeout     = (tmo_cnt >= TW'(TIMEOUT_CYC));
    assign gap_last    = (GAP_CYC <= 1) || (int'(gap_cnt) >= GAP_CYC - 1);
    // A timed-out frame is abandoned even if bytes remain
    assign more_bytes  = !frame_end && (byte_idx != LAST_IDX);

    always_comb begin
        state_nxt  = state;
        o_Tx_Start = 1'b0;
        o_Tx_Err   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD: state_nxt = START;
            START: begin
                if (!i_Tx_Busy) begin
                    o_Tx_Start = 1'b1;
                    state_nxt  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_nxt = GAP;
                end else if (timeout) begin
                    o_Tx_Err  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_last) state_nxt = more_bytes ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (rst_n && push) mem[wr_ptr] <= {i_Rsp_Code, i_Rsp_Data};
    end

    always_ff @(posedge i_Clock) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_code <= 8'h00;
            frame_data <= 8'h00;
            tx_data    <= 8'h00;
            byte_idx   <= 2'd0;
            frame_end  <= 1'b0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            gap_cnt <= '0;

            case (state)
                IDLE: begin
                    // Present byte 0 already while LOAD pops the entry
                    if (!fifo_empty) tx_data <= mem[rd_ptr][15:8];
                end
                LOAD: begin
                    {frame_code, frame_data} <= mem[rd_ptr];
                    byte_idx  <= 2'd0;
                    frame_end <= 1'b0;
                    tmo_cnt   <= '0;
                end
                START: begin
                    if (!timeout) tmo_cnt <= tmo_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        tmo_cnt <= '0;
                    end else begin
                        if (!timeout) tmo_cnt <= tmo_cnt + 1'b1;
                        if (timeout)  frame_end <= 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_last && more_bytes) begin
                        byte_idx <= byte_idx + 2'd1;
                        tx_data  <= frame_byte(byte_idx + 2'd1, frame_code, frame_data);
                        tmo_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
